mul_seq: RTL and testbench
==========================

Name: mul_seq

Overview:
- Multicycle shift-and-add multiplier sequencer for MIPS MULT/MULTU.
- Time-shares a single WIDTH+1-bit adder across WIDTH iterations rather than instantiating an array multiplier.
- Sits beside the ALU and writes the HI/LO pair.
- Start/busy/done handshake with fixed latency so the control unit can stall deterministically.

Parameters:
- WIDTH, 32, operand width; the result is 2*WIDTH bits split into hi/lo.

Ports:
- clk  input  1  clock; all state changes on the rising edge.
- rst  input  1  synchronous, active-high reset.
- start  input  1  request; sampled only in IDLE.
- is_signed  input  1  1 = MULT (two's complement), 0 = MULTU; captured with start.
- a  input  WIDTH  multiplicand; captured with start.
- b  input  WIDTH  multiplier; captured with start.
- busy  output  1  high while an operation is in progress (ABS, RUN, NEG).
- done  output  1  one-cycle pulse; hi/lo are valid in and after this cycle.
- hi  output  WIDTH  upper half of the product.
- lo  output  WIDTH  lower half of the product.

Behaviour:
- Reset (rst=1 at a rising edge):
  - state=IDLE; busy=0, done=0, hi=0, lo=0.
  - Iteration counter and internal operand/accumulator registers cleared.
  - Applies in any state and aborts an in-flight operation with no partial result written.
- States: IDLE, ABS, RUN, NEG, DONE.
- IDLE:
  - start=1 at an edge: capture a, b, is_signed; go to ABS.
  - start=0: remain; hi/lo hold.
- ABS (1 cycle):
  - If is_signed, replace each operand by its magnitude as an unsigned WIDTH-bit value; -2^(WIDTH-1) maps to 2^(WIDTH-1).
  - Record neg = is_signed & (a[WIDTH-1] ^ b[WIDTH-1]).
  - Clear the 2*WIDTH accumulator; counter=0; go to RUN.
- RUN (exactly WIDTH cycles):
  - Each cycle: if multiplier bit 0 = 1, the adder computes {0,acc_hi} + {0,mcand} (WIDTH+1 bits, carry kept); otherwise the sum is acc_hi.
  - Then {carry, sum, acc_lo} shifts right one bit into the accumulator, and the multiplier shifts right one.
  - counter increments; on counter = WIDTH-1, go to NEG.
  - No other adder touches the operand path.
- NEG (1 cycle, always taken so latency is fixed):
  - If neg, the accumulator becomes its 2*WIDTH-bit two's complement; otherwise unchanged.
  - Load hi = acc[2W-1:W] and lo = acc[W-1:0]; go to DONE.
- DONE (1 cycle): done=1, busy=0; go to IDLE. start is ignored in DONE.
- Latency:
  - start high in cycle 0 → busy high cycles 1..WIDTH+2, done high in cycle WIDTH+3 (cycle 35 for WIDTH=32).
  - A new start is accepted no earlier than cycle WIDTH+4.
- start while busy or in DONE: ignored; captured operands are unaffected by input changes after capture.
- hi/lo:
  - Change only at the NEG→DONE edge or on reset.
  - Hold indefinitely otherwise, including while a new operation runs.
- Unsigned results are exact 2*WIDTH-bit products; signed results are exact two's-complement products. No overflow is possible.
- busy and done are never high in the same cycle.

Test Plan:
- Unsigned 7*6, start in cycle 0 → busy cycles 1-34, done=1 only in cycle 35, hi=0x00000000, lo=0x0000002A.
- Unsigned 0xFFFFFFFF*0xFFFFFFFF → hi=0xFFFFFFFE, lo=0x00000001; is_signed=0 with a=0x80000000, b=2 → hi=0x00000001, lo=0x00000000.
- Signed cases:
  - -3*5 (a=0xFFFFFFFD, b=5) → hi=0xFFFFFFFF, lo=0xFFFFFFF1.
  - 0x80000000*0x80000000 → hi=0x40000000, lo=0x00000000.
  - -1*0 → hi=0, lo=0.
- Protocol:
  - Second start pulses with different operands in cycles 5 and 35 → ignored; first result unchanged.
  - Start in cycle 36 → accepted, done in cycle 71.
  - Operands changed after cycle 0 do not affect the result.
- rst=1 at cycle 12 of an operation (prior result hi=1, lo=2 loaded) → next cycle busy=0, done=0, hi=0, lo=0, no done pulse ever.
- After that reset, start 9*9 → hi=0, lo=0x51 with normal latency.

Source files
------------

// File: rtl/mul_seq_if.sv
// mul_seq_if: start/busy/done handshake and operand/result bus for the multiplier.
interface mul_seq_if #(parameter int WIDTH = 32);
  logic             start;
  logic             is_signed;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] hi;
  logic [WIDTH-1:0] lo;
  modport master (output start, is_signed, a, b, input busy, done, hi, lo);
  modport slave  (input start, is_signed, a, b, output busy, done, hi, lo);
endinterface

// File: rtl/mul_seq.sv
// mul_seq: fixed-latency shift-and-add MULT/MULTU sequencer writing HI/LO.
module mul_seq #(
  parameter int WIDTH = 32
) (
  input logic       clk,
  input logic       rst,
  mul_seq_if.slave  bus
);
  localparam int CW = $clog2(WIDTH) + 1;
  typedef enum logic [2:0] {IDLE, ABS, RUN, NEG, DONE} state_t;
  state_t             r_state;
  logic [WIDTH-1:0]   r_mcand;
  logic [WIDTH-1:0]   r_mplier;
  logic [2*WIDTH-1:0] r_acc;
  logic [CW-1:0]      r_cnt;
  logic               r_signed;
  logic               r_neg;
  logic               r_busy;
  logic               r_done;
  logic [WIDTH-1:0]   r_hi;
  logic [WIDTH-1:0]   r_lo;
  logic [WIDTH:0]     w_sum;
  logic [2*WIDTH-1:0] w_res;
  // The single shared adder: carry is kept so it can shift into the accumulator.
  always_comb begin
    w_sum = r_mplier[0] ? {1'b0, r_acc[2*WIDTH-1:WIDTH]} + {1'b0, r_mcand}
                        : {1'b0, r_acc[2*WIDTH-1:WIDTH]};
    w_res = r_neg ? '0 - r_acc : r_acc;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state  <= IDLE;
      r_mcand  <= '0;
      r_mplier <= '0;
      r_acc    <= '0;
      r_cnt    <= '0;
      r_signed <= 1'b0;
      r_neg    <= 1'b0;
      r_busy   <= 1'b0;
      r_done   <= 1'b0;
      r_hi     <= '0;
      r_lo     <= '0;
    end else begin
      case (r_state)
        IDLE: if (bus.start) begin
          r_mcand  <= bus.a;
          r_mplier <= bus.b;
          r_signed <= bus.is_signed;
          r_busy   <= 1'b1;
          r_state  <= ABS;
        end
        ABS: begin
          r_neg    <= r_signed & (r_mcand[WIDTH-1] ^ r_mplier[WIDTH-1]);
          r_mcand  <= (r_signed & r_mcand[WIDTH-1]) ? '0 - r_mcand : r_mcand;
          r_mplier <= (r_signed & r_mplier[WIDTH-1]) ? '0 - r_mplier : r_mplier;
          r_acc    <= '0;
          r_cnt    <= '0;
          r_state  <= RUN;
        end
        RUN: begin
          r_acc    <= {w_sum, r_acc[WIDTH-1:1]};
          r_mplier <= r_mplier >> 1;
          r_cnt    <= r_cnt + CW'(1);
          if (r_cnt == CW'(WIDTH - 1)) r_state <= NEG;
        end
        NEG: begin
          r_acc   <= w_res;
          r_hi    <= w_res[2*WIDTH-1:WIDTH];
          r_lo    <= w_res[WIDTH-1:0];
          r_busy  <= 1'b0;
          r_done  <= 1'b1;
          r_state <= DONE;
        end
        default: begin
          r_done  <= 1'b0;
          r_state <= IDLE;
        end
      endcase
    end
  end
  assign bus.busy = r_busy;
  assign bus.done = r_done;
  assign bus.hi   = r_hi;
  assign bus.lo   = r_lo;
endmodule

// File: tb/tb_mul_seq.sv
// tb_mul_seq: directed-vector bench for mul_seq latency, results, protocol and reset.
module tb_mul_seq;
  logic clk = 1'b0;
  logic rst = 1'b1;
  int   checks = 0;
  int   failures = 0;
  mul_seq_if #(.WIDTH(32)) bus();
  mul_seq #(.WIDTH(32)) dut (.clk(clk), .rst(rst), .bus(bus));
  always #5 clk = ~clk;
  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask
  task automatic tick();
    @(posedge clk);
    #1;
  endtask
  task automatic run_op(input string tag, input logic [31:0] a, input logic [31:0] b,
                        input logic sgn, input logic [31:0] eh, input logic [31:0] el);
    int dc;
    dc = 0;
    bus.a = a;
    bus.b = b;
    bus.is_signed = sgn;
    bus.start = 1'b1;
    for (int k = 1; k <= 40 && dc == 0; k++) begin
      tick();
      bus.start = 1'b0;
      if (k == 1) begin
        bus.a = 32'h1234_5678;
        bus.b = 32'h9ABC_DEF0;
        bus.is_signed = ~sgn;
      end
      check({tag, "_busy"}, 64'(bus.busy), 64'(k <= 34));
      if (bus.done) dc = k;
    end
    check({tag, "_donecyc"}, 64'(dc), 64'd35);
    check({tag, "_hi"}, 64'(bus.hi), 64'(eh));
    check({tag, "_lo"}, 64'(bus.lo), 64'(el));
    tick();
    check({tag, "_donefall"}, 64'(bus.done), 64'd0);
  endtask
  initial begin
    bus.start = 1'b0;
    bus.is_signed = 1'b0;
    bus.a = '0;
    bus.b = '0;
    tick();
    tick();
    check("rst_busy", 64'(bus.busy), 64'd0);
    check("rst_done", 64'(bus.done), 64'd0);
    check("rst_hi", 64'(bus.hi), 64'd0);
    check("rst_lo", 64'(bus.lo), 64'd0);
    rst = 1'b0;
    tick();
    run_op("u7x6", 32'd7, 32'd6, 1'b0, 32'h0, 32'h2A);
    run_op("uffxff", 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0, 32'hFFFF_FFFE, 32'h1);
    run_op("u80x2", 32'h8000_0000, 32'd2, 1'b0, 32'h1, 32'h0);
    run_op("sm3x5", 32'hFFFF_FFFD, 32'd5, 1'b1, 32'hFFFF_FFFF, 32'hFFFF_FFF1);
    run_op("s80x80", 32'h8000_0000, 32'h8000_0000, 1'b1, 32'h4000_0000, 32'h0);
    run_op("sm1x0", 32'hFFFF_FFFF, 32'd0, 1'b1, 32'h0, 32'h0);
    // Protocol: start pulses at 5 and 35 ignored, start at 36 accepted.
    bus.a = 32'd100;
    bus.b = 32'd200;
    bus.is_signed = 1'b0;
    bus.start = 1'b1;
    for (int k = 1; k <= 75; k++) begin
      tick();
      bus.start = (k == 5 || k == 35 || k == 36);
      bus.a = (k == 36) ? 32'd3 : 32'd11;
      bus.b = (k == 36) ? 32'd4 : 32'd13;
      check("proto_done", 64'(bus.done), 64'(k == 35 || k == 71));
      check("proto_excl", 64'(bus.done & bus.busy), 64'd0);
      if (k == 35 || k == 50) check("proto_lo1", 64'({bus.hi, bus.lo}), 64'h4E20);
      if (k == 71) check("proto_lo2", 64'({bus.hi, bus.lo}), 64'd12);
    end
    bus.start = 1'b0;
    tick();
    run_op("pre_rst", 32'h8000_0001, 32'd2, 1'b0, 32'h1, 32'h2);
    bus.a = 32'd5;
    bus.b = 32'd5;
    bus.start = 1'b1;
    for (int k = 1; k <= 12; k++) begin
      tick();
      bus.start = 1'b0;
    end
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check("abort_busy", 64'(bus.busy), 64'd0);
    check("abort_done", 64'(bus.done), 64'd0);
    check("abort_hi", 64'(bus.hi), 64'd0);
    check("abort_lo", 64'(bus.lo), 64'd0);
    begin
      int seen;
      seen = 0;
      for (int k = 0; k < 40; k++) begin
        tick();
        seen += int'(bus.done | bus.busy);
      end
      check("abort_quiet", 64'(seen), 64'd0);
    end
    run_op("u9x9", 32'd9, 32'd9, 1'b0, 32'h0, 32'h51);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
